dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 149 ++++++++++++++
 tb/tb_dmem_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: combinational reads, byte-lane stores, store counter.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        MisalignFlag,
  output logic [31:0] MisalignAddr,
  output logic [31:0] StoreCount
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [AddrW-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_val;
  logic             misalign;
  logic             store_en;
  logic [3:0]       byte_en;
  logic [31:0]      wr_word;
  logic [31:0]      store_count_q, store_count_d;

  assign word_idx = ALUResultM[AddrW+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    byte_v = rd_word[7:0];
    unique case (ALUResultM[1:0])
      2'b00: byte_v = rd_word[7:0];
      2'b01: byte_v = rd_word[15:8];
      2'b10: byte_v = rd_word[23:16];
      2'b11: byte_v = rd_word[31:24];
      default: byte_v = rd_word[7:0];
    endcase
    half_v = ALUResultM[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_val = rd_word;
    case (funct3M)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = rd_word;
    endcase
  end

  assign ReadDataM = (misalign && MemReadM) ? 32'h0 : load_val;

  // Lane enables; half/word lanes ignore the low address bits, which force-aligns.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        byte_en = 4'b0001 << ALUResultM[1:0];
        wr_word = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        byte_en = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_word = WriteDataM;
      end
      default: begin
        byte_en = 4'b0000;
        wr_word = WriteDataM;
      end
    endcase
  end

  assign store_en = MemWriteM && !reset && !funct3M[2] && (funct3M[1:0] != 2'b11) && !misalign;

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign store_count_d = store_en ? store_count_q + 32'd1 : store_count_q;

  always_ff @(posedge clk) begin
    if (reset) store_count_q <= 32'h0;
    else       store_count_q <= store_count_d;
  end

  assign StoreCount = store_count_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic        is_half, is_word;
  logic        misalign_flag_q, misalign_flag_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;

  assign is_half  = (funct3M[1:0] == 2'b01);
  assign is_word  = (funct3M[1:0] == 2'b10);
  assign misalign = (MemReadM || MemWriteM) &&
                    ((is_half && ALUResultM[0]) || (is_word && (ALUResultM[1:0] != 2'b00)));

  // Only the first misaligned access since reset is recorded.
  always_comb begin
    misalign_flag_d = misalign_flag_q;
    misalign_addr_d = misalign_addr_q;
    if (misalign && !misalign_flag_q) begin
      misalign_flag_d = 1'b1;
      misalign_addr_d = ALUResultM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_flag_q <= 1'b0;
      misalign_addr_q <= 32'h0;
    end else begin
      misalign_flag_q <= misalign_flag_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign MisalignM    = misalign;
  assign MisalignFlag = misalign_flag_q;
  assign MisalignAddr = misalign_addr_q;
`else
  logic unused_sig;

  assign unused_sig   = ^{MemReadM, ALUResultM[31:AddrW+2]};
  assign misalign     = 1'b0;
  assign MisalignM    = 1'b0;
  assign MisalignFlag = 1'b0;
  assign MisalignAddr = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a byte-level memory model checked every cycle,
// plus hand-computed literal expectations along the stimulus.
module tb_dmem_lsu;

  localparam int unsigned Depth = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic        MemReadM = 1'b0;
  logic [2:0]  funct3M = 3'b010;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] ReadDataM;
  logic        MisalignM;
  logic        MisalignFlag;
  logic [31:0] MisalignAddr;
  logic [31:0] StoreCount;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(Depth)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .MemReadM     (MemReadM),
    .funct3M      (funct3M),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .ReadDataM    (ReadDataM),
    .MisalignM    (MisalignM),
    .MisalignFlag (MisalignFlag),
    .MisalignAddr (MisalignAddr),
    .StoreCount   (StoreCount)
  );

  // Reference model state
  logic [31:0] m_mem   [Depth];
  logic [3:0]  m_known [Depth];
  logic [31:0] m_cnt;
  logic        m_flag;
  logic [31:0] m_addr;
  bit          model_ok = 1'b0;

  initial begin
    for (int i = 0; i < Depth; i++) begin
      m_mem[i]   = 32'h0;
      m_known[i] = 4'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mis(input logic we, input logic re, input logic [2:0] f3,
                                input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (!Trap || !(we || re)) return 1'b0;
    if (f3[1:0] == 2'b01 && (off % 2) == 1) return 1'b1;
    if (f3[1:0] == 2'b10 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Model update on each rising edge, from the inputs held across it.
  always @(posedge clk) begin
    int unsigned idx, off;
    bit m;
    idx = (ALUResultM / 4) % Depth;
    off = ALUResultM % 4;
    m   = is_mis(MemWriteM, MemReadM, funct3M, ALUResultM);
    if (reset) begin
      m_cnt    <= 32'h0;
      m_flag   <= 1'b0;
      m_addr   <= 32'h0;
      model_ok <= 1'b1;
    end else begin
      if (m && !m_flag) begin
        m_flag <= 1'b1;
        m_addr <= ALUResultM;
      end
      // Only SB/SH/SW (funct3 0..2) are real stores.
      if (MemWriteM && funct3M <= 3'd2 && !m) begin
        for (int k = 0; k < 4; k++) begin
          if (funct3M == 3'd0 && k == off) begin
            m_mem[idx][8*k +: 8] <= WriteDataM[7:0];
            m_known[idx][k]      <= 1'b1;
          end else if (funct3M == 3'd1 && (k / 2) == (off / 2)) begin
            m_mem[idx][8*k +: 8] <= WriteDataM[8*(k%2) +: 8];
            m_known[idx][k]      <= 1'b1;
          end else if (funct3M == 3'd2) begin
            m_mem[idx][8*k +: 8] <= WriteDataM[8*k +: 8];
            m_known[idx][k]      <= 1'b1;
          end
        end
        m_cnt <= m_cnt + 32'd1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int unsigned idx;
    bit m;
    if (model_ok) begin
      idx = (ALUResultM / 4) % Depth;
      m   = is_mis(MemWriteM, MemReadM, funct3M, ALUResultM);
      check("model MisalignM", {31'h0, MisalignM}, {31'h0, m});
      check("model MisalignFlag", {31'h0, MisalignFlag}, {31'h0, m_flag});
      check("model MisalignAddr", MisalignAddr, m_addr);
      check("model StoreCount", StoreCount, m_cnt);
      if (m && MemReadM)
        check("model ReadDataM(misaligned)", ReadDataM, 32'h0);
      else if (m_known[idx] == 4'hF)
        check("model ReadDataM", ReadDataM, exp_load(funct3M, ALUResultM, m_mem[idx]));
    end
  end

  task automatic cyc(input logic rst, input logic we, input logic re, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset      = rst;
    MemWriteM  = we;
    MemReadM   = re;
    funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    @(negedge clk);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    check("reset StoreCount", StoreCount, 32'h0);
    check("reset MisalignFlag", {31'h0, MisalignFlag}, 32'h0);
    check("reset MisalignAddr", MisalignAddr, 32'h0);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h0);
    check("LW 0x10", ReadDataM, 32'hDEADBEEF);
    check("count after SW", StoreCount, 32'd1);

    cyc(1'b0, 1'b1, 1'b0, 3'd0, 32'h11, 32'h0000007F);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'h11, 32'h0);
    check("LB 0x11", ReadDataM, 32'h0000007F);
    cyc(1'b0, 1'b0, 1'b1, 3'd4, 32'h13, 32'h0);
    check("LBU 0x13", ReadDataM, 32'h000000DE);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'h13, 32'h0);
    check("LB 0x13", ReadDataM, 32'hFFFFFFDE);
    cyc(1'b0, 1'b0, 1'b1, 3'd1, 32'h12, 32'h0);
    check("LH 0x12", ReadDataM, 32'hFFFFDEAD);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 3'd2, 32'h20, 32'h12345678);
    check("read-before-write", ReadDataM, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h0);
    check("LW 0x20 after SW", ReadDataM, 32'h12345678);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0000C0DE);
    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h22, 32'hAABBCCDD);
    check("SW 0x22 MisalignM", {31'h0, MisalignM}, Trap ? 32'd1 : 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h0);
    check("LW 0x20 after SW 0x22", ReadDataM, Trap ? 32'h12345678 : 32'hAABBCCDD);
    check("flag after SW 0x22", {31'h0, MisalignFlag}, Trap ? 32'd1 : 32'd0);
    check("addr after SW 0x22", MisalignAddr, Trap ? 32'h22 : 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 3'd1, 32'h31, 32'h0);
    check("LH 0x31", ReadDataM, Trap ? 32'h0 : 32'hFFFFC0DE);
    cyc(1'b0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    check("addr sticky", MisalignAddr, Trap ? 32'h22 : 32'h0);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h1010, 32'hCAFEF00D);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h0);
    check("alias LW 0x10", ReadDataM, 32'hCAFEF00D);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h40, 32'h11111111);
    cyc(1'b0, 1'b1, 1'b0, 3'd3, 32'h40, 32'hFFFFFFFF);
    cyc(1'b0, 1'b1, 1'b0, 3'd6, 32'h40, 32'hFFFFFFFF);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h40, 32'h0);
    check("suppressed stores", ReadDataM, 32'h11111111);
    check("count after suppressed", StoreCount, Trap ? 32'd7 : 32'd8);

    cyc(1'b0, 1'b1, 1'b0, 3'd1, 32'h42, 32'h0000BEEF);
    cyc(1'b0, 1'b0, 1'b1, 3'd5, 32'h42, 32'h0);
    check("LHU 0x42", ReadDataM, 32'h0000BEEF);
    cyc(1'b0, 1'b0, 1'b1, 3'd1, 32'h40, 32'h0);
    check("LH 0x40", ReadDataM, 32'h00001111);

    cyc(1'b0, 1'b1, 1'b0, 3'd2, 32'h50, 32'h01020304);
    cyc(1'b1, 1'b1, 1'b0, 3'd2, 32'h50, 32'hFFFFFFFF);
    cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'h50, 32'h0);
    check("store under reset", ReadDataM, 32'h01020304);
    check("count after reset", StoreCount, 32'h0);
    check("flag after reset", {31'h0, MisalignFlag}, 32'h0);
    check("addr after reset", MisalignAddr, 32'h0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
